// File: rtl/dlfloat_pkg.sv
// DLFloat16 field layout, special encodings and the shared result packer.
// DLFLOAT_SAT_EN: saturate/flush out-of-range exponents; otherwise they wrap modulo 64.
package dlfloat_pkg;

    localparam int          EXP_W    = 6;
    localparam int          MAN_W    = 9;
    localparam int          BIAS     = 31;
    localparam logic [15:0] DLF_ZERO = 16'h0000;
    localparam logic [15:0] DLF_NAN  = 16'hFFFF;
    localparam logic [15:0] DLF_MAX  = 16'h7DFF;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] expo;
        logic [MAN_W-1:0] mant;
    } dlf_t;

    // expo is a signed, unbounded biased exponent; mant excludes the hidden bit
    function automatic logic [15:0] dlf_pack(input logic sign,
                                             input logic signed [7:0] expo,
                                             input logic [MAN_W-1:0] mant);
        dlf_t r;
`ifdef DLFLOAT_SAT_EN
        if (expo > 8'sd62) return {sign, DLF_MAX[14:0]};
        if (expo < 8'sd1)  return DLF_ZERO;
`endif
        r.sign = sign;
        r.expo = EXP_W'(expo);
        r.mant = mant;
        return r;
    endfunction

endpackage

// File: rtl/dlfloat_dot_acc_add_comb.sv
// Combinational DLFloat16 adder: align smaller operand (truncating), add/subtract,
// renormalise. Zero passes the other operand through, NaN is absorbing.
module dlfloat_add_comb
    import dlfloat_pkg::*;
(
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] sum_o
);

    logic [15:0]       big, sml;
    logic [MAN_W:0]    mb, ms, ms_al;
    logic [EXP_W-1:0]  ediff;
    logic [MAN_W+1:0]  raw;
    logic [3:0]        lz;
    logic              found;
    logic signed [7:0] e_res;
    logic [MAN_W-1:0]  m_res;

    always_comb begin
        // order by magnitude so the result takes the sign of the larger operand
        if (a_i[14:0] < b_i[14:0]) begin
            big = b_i;
            sml = a_i;
        end else begin
            big = a_i;
            sml = b_i;
        end
        mb    = {1'b1, big[MAN_W-1:0]};
        ms    = {1'b1, sml[MAN_W-1:0]};
        ediff = big[14:9] - sml[14:9];
        ms_al = (ediff > 6'd9) ? '0 : (ms >> ediff);
        raw   = (big[15] == sml[15]) ? ({1'b0, mb} + {1'b0, ms_al})
                                     : ({1'b0, mb} - {1'b0, ms_al});
        lz    = '0;
        found = 1'b0;
        for (int i = MAN_W; i >= 0; i--) begin
            if (!found && raw[i]) begin
                lz    = 4'(MAN_W - i);
                found = 1'b1;
            end
        end
        if (raw[MAN_W+1]) begin
            m_res = raw[MAN_W:1];
            e_res = $signed({2'b00, big[14:9]}) + 8'sd1;
        end else begin
            m_res = MAN_W'(raw[MAN_W:0] << lz);
            e_res = $signed({2'b00, big[14:9]}) - $signed({4'b0000, lz});
        end

        if (a_i == DLF_NAN || b_i == DLF_NAN) sum_o = DLF_NAN;
        else if (a_i == DLF_ZERO)             sum_o = b_i;
        else if (b_i == DLF_ZERO)             sum_o = a_i;
        else if (raw == '0)                   sum_o = DLF_ZERO;
        else                                  sum_o = dlf_pack(big[15], e_res, m_res);
    end

endmodule

// File: rtl/dlfloat_dot_acc.sv
// Multi-channel streaming DLFloat16 MAC: capture -> multiply -> accumulate -> result FIFO.
// Build with DLFLOAT_SAT_EN for saturating exponents (see dlfloat_pkg).
module dlfloat_dot_acc
    import dlfloat_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int OUT_DEPTH = 4,
    parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [15:0]     in_a,
    input  logic [15:0]     in_b,
    input  logic [CH_W-1:0] in_ch,
    input  logic            in_first,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     out_data,
    output logic [CH_W-1:0] out_ch,
    output logic            out_nan
);

    localparam int AW = $clog2(OUT_DEPTH);

    logic            i_valid_q, i_first_q, i_last_q;
    logic [15:0]     i_a_q, i_b_q;
    logic [CH_W-1:0] i_ch_q;
    logic            m_valid_q, m_first_q, m_last_q;
    logic [15:0]     m_prod_q;
    logic [CH_W-1:0] m_ch_q;

    logic [2*MAN_W+1:0] man_prod;
    logic [MAN_W-1:0]   m_man;
    logic [7:0]         e_prod;
    logic [15:0]        prod_d, acc_op, sum_d;
    logic [15:0]        acc_q [NUM_CH];

    logic [15:0]     fifo_data_q [OUT_DEPTH];
    logic [CH_W-1:0] fifo_ch_q   [OUT_DEPTH];
    logic [AW:0]     wr_ptr_q, rd_ptr_q, count;
    logic [AW+1:0]   credits;
    logic            accept, push, pop;

    // every last pair already past the input port holds a FIFO slot
    assign count    = wr_ptr_q - rd_ptr_q;
    assign credits  = {1'b0, count} + (AW+2)'(i_valid_q & i_last_q)
                                    + (AW+2)'(m_valid_q & m_last_q);
    assign in_ready = !rst && (credits < (AW+2)'(OUT_DEPTH));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_valid_q <= 1'b0;
            i_a_q     <= '0;
            i_b_q     <= '0;
            i_ch_q    <= '0;
            i_first_q <= 1'b0;
            i_last_q  <= 1'b0;
        end else begin
            i_valid_q <= accept;
            if (accept) begin
                i_a_q     <= in_a;
                i_b_q     <= in_b;
                i_ch_q    <= in_ch;
                i_first_q <= in_first;
                i_last_q  <= in_last;
            end
        end
    end

    always_comb begin
        man_prod = {1'b1, i_a_q[MAN_W-1:0]} * {1'b1, i_b_q[MAN_W-1:0]};
        m_man    = man_prod[2*MAN_W+1] ? MAN_W'(man_prod >> (MAN_W + 1))
                                       : MAN_W'(man_prod >> MAN_W);
        e_prod   = {2'b00, i_a_q[14:9]} + {2'b00, i_b_q[14:9]}
                 + {7'd0, man_prod[2*MAN_W+1]} - 8'(BIAS);
        if (i_a_q == DLF_NAN || i_b_q == DLF_NAN)        prod_d = DLF_NAN;
        else if (i_a_q == DLF_ZERO || i_b_q == DLF_ZERO) prod_d = DLF_ZERO;
        else prod_d = dlf_pack(i_a_q[15] ^ i_b_q[15], $signed(e_prod), m_man);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_prod_q  <= '0;
            m_ch_q    <= '0;
            m_first_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            m_valid_q <= i_valid_q;
            if (i_valid_q) begin
                m_prod_q  <= prod_d;
                m_ch_q    <= i_ch_q;
                m_first_q <= i_first_q;
                m_last_q  <= i_last_q;
            end
        end
    end

    assign acc_op = m_first_q ? DLF_ZERO : acc_q[m_ch_q];

    dlfloat_add_comb u_add (
        .a_i   (acc_op),
        .b_i   (m_prod_q),
        .sum_o (sum_d)
    );

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_acc
        always_ff @(posedge clk or posedge rst) begin
            if (rst)                                    acc_q[gi] <= DLF_ZERO;
            else if (m_valid_q && m_ch_q == CH_W'(gi))  acc_q[gi] <= sum_d;
        end
    end

    assign push = m_valid_q && m_last_q;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q[AW-1:0]] <= sum_d;
            fifo_ch_q[wr_ptr_q[AW-1:0]]   <= m_ch_q;
        end
    end

    assign out_valid = (count != '0);
    assign out_data  = out_valid ? fifo_data_q[rd_ptr_q[AW-1:0]] : DLF_ZERO;
    assign out_ch    = out_valid ? fifo_ch_q[rd_ptr_q[AW-1:0]] : '0;
    assign out_nan   = out_valid && (out_data == DLF_NAN);

endmodule

// File: tb/tb_dlfloat_dot_acc.sv
// Scoreboard bench for dlfloat_dot_acc: directed scenarios plus randomized traffic
// against an integer-arithmetic reference model.
module tb_dlfloat_dot_acc;

    localparam int NUM_CH    = 4;
    localparam int OUT_DEPTH = 4;
    localparam int CH_W      = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic            in_ready, out_valid, out_nan;
    logic [15:0]     in_a = '0, in_b = '0, out_data;
    logic [CH_W-1:0] in_ch = '0, out_ch;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit rand_rdy  = 1'b0;

    typedef struct {
        logic [15:0]     d;
        logic [CH_W-1:0] ch;
    } res_t;

    res_t            exp_q[$];
    logic [15:0]     got_d[$];
    logic [CH_W-1:0] got_ch[$];
    logic            got_nan[$];
    logic [15:0]     model_acc [NUM_CH];
    logic [15:0]     bp_vals [5];

    dlfloat_dot_acc #(.NUM_CH(NUM_CH), .OUT_DEPTH(OUT_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_ch(in_ch),
        .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ch(out_ch), .out_nan(out_nan)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total_cnt++;
        if (act === want) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, want);
    endtask

    // ---------------- reference model: value = mant * 2^exp with integer truncation
    function automatic logic [15:0] m_pack(input int s, input int e, input int m);
`ifdef DLFLOAT_SAT_EN
        if (e > 62) return (s != 0) ? 16'hFDFF : 16'h7DFF;
        if (e < 1)  return 16'h0000;
`endif
        return {s[0], 6'(e & 63), 9'(m & 511)};
    endfunction

    function automatic logic [15:0] m_mul(input logic [15:0] a, input logic [15:0] b);
        int m, e;
        if (a == 16'hFFFF || b == 16'hFFFF) return 16'hFFFF;
        if (a == 16'h0000 || b == 16'h0000) return 16'h0000;
        m = ((512 + int'(a[8:0])) * (512 + int'(b[8:0]))) >> 9;
        e = int'(a[14:9]) + int'(b[14:9]) - 31;
        if (m >= 1024) begin
            m = m >> 1;
            e++;
        end
        return m_pack(int'(a[15] ^ b[15]), e, m);
    endfunction

    function automatic logic [15:0] m_add(input logic [15:0] x, input logic [15:0] y);
        int ex, ey, e, vx, vy, sum, mag;
        if (x == 16'hFFFF || y == 16'hFFFF) return 16'hFFFF;
        if (x == 16'h0000) return y;
        if (y == 16'h0000) return x;
        ex = int'(x[14:9]);
        ey = int'(y[14:9]);
        e  = (ex > ey) ? ex : ey;
        vx = (e - ex > 15) ? 0 : ((512 + int'(x[8:0])) >> (e - ex));
        vy = (e - ey > 15) ? 0 : ((512 + int'(y[8:0])) >> (e - ey));
        sum = (x[15] ? -vx : vx) + (y[15] ? -vy : vy);
        if (sum == 0) return 16'h0000;
        mag = (sum < 0) ? -sum : sum;
        while (mag >= 1024) begin mag = mag >> 1; e++; end
        while (mag < 512)   begin mag = mag << 1; e--; end
        return m_pack((sum < 0) ? 1 : 0, e, mag);
    endfunction

    task automatic model_accept(input logic [15:0] a, input logic [15:0] b, input int ch,
                                input bit first, input bit last);
        logic [15:0] s;
        s = m_add(first ? 16'h0000 : model_acc[ch], m_mul(a, b));
        model_acc[ch] = s;
        if (last) exp_q.push_back('{d: s, ch: CH_W'(ch)});
    endtask

    // ---------------- stimulus helpers (entered and left at posedge+1)
    task automatic send(input logic [15:0] a, input logic [15:0] b, input int ch,
                        input bit first, input bit last);
        int  waited = 0;
        bit  ok = 1'b0;
        in_valid = 1'b1; in_a = a; in_b = b; in_ch = CH_W'(ch);
        in_first = first; in_last = last;
        while (!ok && waited <= 500) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else begin
                waited++;
                @(posedge clk); #1;
            end
        end
        if (ok) begin
            model_accept(a, b, ch, first, last);
            @(posedge clk); #1;
        end else begin
            total_cnt++;
            $display("FAIL send_timeout: in_ready 0 after %0d cycles, required 1", waited);
            in_valid = 1'b0;
        end
    endtask

    task automatic idle();
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_got(input int n);
        int c = 0;
        while (got_d.size() < n && c < 300) begin
            @(posedge clk); #1;
            c++;
        end
        if (got_d.size() < n) begin
            total_cnt++;
            $display("FAIL wait_results: got %0d results, required %0d", got_d.size(), n);
            while (got_d.size() < n) begin
                got_d.push_back('x); got_ch.push_back('x); got_nan.push_back(1'bx);
            end
        end
    endtask

    task automatic clear_got();
        got_d.delete(); got_ch.delete(); got_nan.delete();
    endtask

    function automatic logic [15:0] rnd_op();
        int r;
        r = $urandom_range(0, 99);
        if (r < 3) return 16'hFFFF;
        if (r < 8) return 16'h0000;
        return {1'($urandom_range(0, 1)), 6'($urandom_range(27, 35)), 9'($urandom)};
    endfunction

    // ---------------- monitor: pop and compare on every output handshake
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_ch.push_back(out_ch);
                got_nan.push_back(out_nan);
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_result: got data %h ch %0d, required none", out_data, out_ch);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_data", 32'(out_data), 32'(e.d));
                    chk("sb_ch", 32'(out_ch), 32'(e.ch));
                    chk("sb_nan", 32'(out_nan), 32'(e.d == 16'hFFFF));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #2;
            if (rand_rdy) out_ready = ($urandom_range(0, 9) < 7);
        end
    end

    initial begin
        for (int i = 0; i < NUM_CH; i++) model_acc[i] = 16'h0000;
        bp_vals[0] = 16'h3E00; bp_vals[1] = 16'h4000; bp_vals[2] = 16'h4100;
        bp_vals[3] = 16'h4200; bp_vals[4] = 16'h4280;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_ch", 32'(out_ch), 0);
        chk("rst_out_nan", 32'(out_nan), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(in_ready), 1);
        @(posedge clk); #1;
        out_ready = 1'b1;

        // single-channel sum with latency check
        clear_got();
        send(16'h3E00, 16'h4000, 0, 1, 0);
        send(16'h4000, 16'h3F00, 0, 0, 1);
        idle();
        @(posedge clk); @(negedge clk);
        chk("lat_edge1_valid", 32'(out_valid), 0);
        @(posedge clk); @(negedge clk);
        chk("lat_edge2_valid", 32'(out_valid), 1);
        chk("single_sum", 32'(out_data), 32'h4280);
        chk("single_ch", 32'(out_ch), 0);
        @(posedge clk); #1;

        // channel interleave
        clear_got();
        for (int k = 0; k < 8; k++) send(16'h3E00, 16'h3E00, k % 2, k < 2, k >= 6);
        idle();
        wait_got(2);
        chk("ilv_d0", 32'(got_d[0]), 32'h4200);
        chk("ilv_ch0", 32'(got_ch[0]), 0);
        chk("ilv_d1", 32'(got_d[1]), 32'h4200);
        chk("ilv_ch1", 32'(got_ch[1]), 1);

        // cancellation, then sticky NaN
        clear_got();
        send(16'h4000, 16'h3F00, 2, 1, 0);
        send(16'hC100, 16'h3E00, 2, 0, 1);
        send(16'hFFFF, 16'h3E00, 2, 1, 0);
        send(16'h3E00, 16'h3E00, 2, 0, 1);
        idle();
        wait_got(2);
        chk("cancel_zero", 32'(got_d[0]), 32'h0000);
        chk("cancel_nan_flag", 32'(got_nan[0]), 0);
        chk("nan_sticky", 32'(got_d[1]), 32'hFFFF);
        chk("nan_flag", 32'(got_nan[1]), 1);

        // exponent overflow
        clear_got();
        send(16'h7C00, 16'h7C00, 3, 1, 1);
        idle();
        wait_got(1);
`ifdef DLFLOAT_SAT_EN
        chk("overflow", 32'(got_d[0]), 32'h7DFF);
`else
        chk("overflow", 32'(got_d[0]), 32'h3A00);
`endif

        // backpressure: credits exhausted at OUT_DEPTH queued/in-flight results
        out_ready = 1'b0;
        clear_got();
        for (int k = 0; k < OUT_DEPTH; k++) send(bp_vals[k], 16'h3E00, 0, 1, 1);
        idle();
        @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 0);
        repeat (2) @(negedge clk);
        chk("bp_hold_valid", 32'(out_valid), 1);
        chk("bp_hold_data", 32'(out_data), 32'h3E00);
        chk("bp_in_ready_held", 32'(in_ready), 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(bp_vals[4], 16'h3E00, 0, 1, 1);
        idle();
        wait_got(5);
        for (int k = 0; k < 5; k++) chk($sformatf("bp_order%0d", k), 32'(got_d[k]), 32'(bp_vals[k]));
        repeat (5) @(posedge clk); #1;
        chk("bp_no_dup", 32'(got_d.size()), 5);

        // reset mid-stream: 3 results queued, one pair in the multiply stage
        out_ready = 1'b0;
        send(16'h3E00, 16'h4000, 1, 1, 1);
        send(16'h3E00, 16'h4000, 1, 0, 1);
        send(16'h3E00, 16'h4000, 1, 0, 1);
        send(16'h4000, 16'h3E00, 1, 0, 0);
        idle();
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        for (int i = 0; i < NUM_CH; i++) model_acc[i] = 16'h0000;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_in_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        clear_got();
        send(16'h4000, 16'h3E00, 1, 0, 1);
        idle();
        wait_got(1);
        chk("post_rst_sum", 32'(got_d[0]), 32'h4000);
        chk("post_rst_count", 32'(got_d.size()), 1);

        // randomized traffic with random backpressure
        rand_rdy = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
                @(posedge clk); #1;
            end
            send(rnd_op(), rnd_op(), int'($urandom_range(0, NUM_CH - 1)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end
        idle();
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 500 && exp_q.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        repeat (4) @(posedge clk); #1;
        chk("drain_empty", 32'(exp_q.size()), 0);
        chk("final_out_valid", 32'(out_valid), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/dlfloat_dot_acc.md
# dlfloat_dot_acc

Streaming DLFloat16 multiply-accumulate engine with multiple independent accumulator channels, a valid/ready operand port, and a buffered result port. It is the parametrised successor of the single-accumulator DLFloat MAC. Per operand pair it selects a channel, optionally restarts or closes the running sum, and queues the closed sums for a downstream consumer. It sits between the operand register wrapper and the output serializer.

## Interface
- NUM_CH, 4: number of independent accumulator channels (1..16).
- OUT_DEPTH, 4: result FIFO depth (power of two, ≥2).
- CH_W, $clog2(NUM_CH) (min 1): channel index width (derived).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  engine can accept a pair this cycle.
- in_a, in_b  in  16 each  DLFloat16 operands.
- in_ch  in  CH_W  target accumulator channel.
- in_first  in  1  discard the channel's old sum; start from this product.
- in_last  in  1  after accumulating, push the channel's sum to the FIFO.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes the head.
- out_data  out  16  result sum.
- out_ch  out  CH_W  channel of the result.
- out_nan  out  1  result is 16'hFFFF.

## Operation
- Format: sign[15], exp[14:9] with bias 31, mant[8:0] with a hidden 1. 16'h0000 is zero. 16'hFFFF is NaN/special.
- Transfer: a pair is accepted when in_valid & in_ready.
- Stage M: combinational multiply, registered.
  - Mantissa product is 10×10 → 20 bits. Normalise on bit 19 and truncate.
  - Exponent = ea + eb − 31 (+1 if normalised up).
  - Sign = XOR of operand signs.
  - Either operand 16'hFFFF → product 16'hFFFF. Otherwise either operand zero → product 0.
- Stage A: read-modify-write of acc[in_ch].
  - in_first=1: the stage A operand is 0 and the product passes through.
  - Adder: align the smaller exponent and truncate, then add or subtract, then renormalise.
  - Zero operand → result is the other operand. Exact cancellation → 16'h0000. Any 16'hFFFF → 16'hFFFF.
  - NaN is sticky in the channel until the next in_first.
  - in_last=1: the new sum {sum, ch} is pushed into the FIFO. The accumulator still holds that sum.
- Back-to-back pairs to the same channel need no stall; the accumulator is read and written in stage A.
- Credit accounting: in_ready = (fifo_count + in-flight last pairs in stage M) < OUT_DEPTH. The FIFO therefore never overflows.
- FIFO: first-word-fall-through, 2's-complement pointer wrap. Push and pop in the same cycle leave the count unchanged. A pop while empty is ignored.
- Reset:
  - in_ready=0 during reset, then 1 on the first cycle after release.
  - out_valid=0, out_data=0, out_ch=0, out_nan=0.
  - All accumulators = 0; stage M invalid; FIFO empty.
  - Asserting rst mid-operation drops all in-flight and queued results.

## Timing
- Pair accepted at edge 0, product registered at edge 1, accumulated at edge 2.
- With in_last=1 and an empty FIFO, out_valid=1 after edge 2: latency is 2 cycles.
- Throughput is 1 pair/cycle while out_ready=1.
- out_* holds stable while out_valid & !out_ready.
- in_ready is combinational from registered state only, with no path from in_valid.

## Configuration
- DLFLOAT_SAT_EN defined:
  - Exponent overflow (> 62) in multiply or add saturates to ±max finite, 16'h7DFF / 16'hFDFF.
  - Exponent underflow (< 1) flushes to 16'h0000.
- DLFLOAT_SAT_EN undefined: the exponent wraps modulo 64, matching the legacy MAC.

## Structure
- Shared package dlfloat_pkg:
  - field widths: EXP_W=6, MAN_W=9.
  - BIAS=31.
  - DLF_ZERO=16'h0000, DLF_NAN=16'hFFFF, DLF_MAX=16'h7DFF.
  - a pack/unpack typedef struct {sign, exp, mant}.
- Sub-module dlfloat_add_comb: the combinational aligner/adder/renormaliser, instantiated once in stage A.
- The multiplier and FIFO stay inline.

## Test plan
- Single-channel sum: ch0 pair (3E00×4000, first) then pair (4000×3F00, last) → out_data=16'h4280 (5.0), out_ch=0, out_valid two cycles after the second acceptance.
- Channel interleave: alternate ch0/ch1, 4 pairs each of 3E00×3E00 (last on the 4th) → two results 16'h4200 (4.0), in push order ch0 then ch1.
- Cancellation and NaN:
  - 4000×3F00 (first) then C100×3E00 (last) → 16'h0000.
  - Then FFFF×3E00 (first), 3E00×3E00 (last) → 16'hFFFF with out_nan=1.
- Backpressure: OUT_DEPTH=2, out_ready=0, three last pairs → in_ready=0 after two are credited; release out_ready → all three results delivered, none lost or duplicated.
- Saturation: 7C00×7C00 (first, last) → 16'h7DFF with DLFLOAT_SAT_EN, 16'h3A00 without.
- Reset mid-stream: assert rst with 3 queued results and one pair in stage M → out_valid=0 next cycle. After release, a new sum excludes all pre-reset data.
